// File: rtl/tx_arbiter_if.sv
// Requester/transmitter-side bundle of the tx_arbiter block.
// Ports: req/req_data from the four requesters, rdy from the UART transmitter;
//        ack/grant/tx_byte/stb/busy/timeout_err back from the arbiter.
interface tx_arbiter_if;
    logic [3:0]  req;          // per-requester byte pending
    logic [31:0] req_data;     // requester i drives [8i+7:8i]
    logic [3:0]  ack;          // one-hot pulse: byte of requester i taken
    logic [1:0]  grant;        // requester currently or last served
    logic [7:0]  tx_byte;      // byte presented to the transmitter
    logic        stb;          // one-cycle strobe to the transmitter
    logic        rdy;          // transmitter idle
    logic        busy;         // arbiter not in IDLE
    logic        timeout_err;  // one-cycle pulse on abandoned transfer

    // master: the arbiter itself
    modport master (
        input  req, req_data, rdy,
        output ack, grant, tx_byte, stb, busy, timeout_err
    );

    // slave: requesters plus transmitter
    modport slave (
        output req, req_data, rdy,
        input  ack, grant, tx_byte, stb, busy, timeout_err
    );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding bytes from four requesters into one UART transmitter.
// Latency: stb/ack one cycle after an IDLE cycle with rdy=1 and a pending request.
// Backpressure: no grant while rdy=0; waits for rdy to fall (bounded by TIMEOUT) then rise.
// Ports: clk, res_n (async active-low); bus (master) carries req/req_data/rdy in and
//        ack/grant/tx_byte/stb/busy/timeout_err out.
module tx_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         res_n,
    tx_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STRB, WBSY, WDON} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_grant;
    logic [1:0]    r_last;
    logic [7:0]    r_tx;
    logic          r_stb;
    logic [3:0]    r_ack;
    logic          r_terr;

    logic          w_hit;
    logic [1:0]    w_sel;
    logic [1:0]    w_idx;
    logic [7:0]    w_byte;

    // Search starts just after the last served requester; the 2-bit add wraps mod 4.
    always_comb begin
        w_hit = 1'b0;
        w_sel = 2'd0;
        w_idx = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_hit && bus.req[w_idx]) begin
                w_hit = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    assign w_byte = bus.req_data[{w_sel, 3'b000} +: 8];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_grant <= 2'd0;
            r_last  <= 2'd3;
            r_tx    <= 8'h00;
            r_stb   <= 1'b0;
            r_ack   <= 4'b0000;
            r_terr  <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle below.
            r_stb  <= 1'b0;
            r_ack  <= 4'b0000;
            r_terr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.rdy && w_hit) begin
                        r_grant <= w_sel;
                        r_tx    <= w_byte;
                        r_stb   <= 1'b1;
                        r_ack   <= 4'b0001 << w_sel;
                        r_state <= STRB;
                    end
                end
                STRB: begin
                    r_cnt   <= '0;
                    r_state <= WBSY;
                end
                WBSY: begin
                    if (!bus.rdy) begin
                        r_state <= WDON;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // Counter lands on TIMEOUT together with the error pulse, so
                        // timeout_err appears TIMEOUT+1 cycles after stb and never wraps.
                        r_cnt   <= r_cnt + CW'(1);
                        r_terr  <= 1'b1;
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WDON: begin
                    if (bus.rdy) begin
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ack         = r_ack;
    assign bus.grant       = r_grant;
    assign bus.tx_byte     = r_tx;
    assign bus.stb         = r_stb;
    assign bus.timeout_err = r_terr;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios plus randomized requesters and a
// transmitter model whose rdy behaviour is chosen per byte.
module tb_tx_arbiter;
    localparam int T = 15;

    logic clk = 1'b0;
    logic res_n;
    always #5 clk = ~clk;

    tx_arbiter_if bus ();

    tx_arbiter #(.TIMEOUT(T)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    int npass = 0;
    int nchk  = 0;

    // Outputs sampled at the falling edge
    logic       s_stb, s_terr, s_busy;
    logic [3:0] s_ack;
    logic [1:0] s_grant;
    logic [7:0] s_tx;

    // Reference model state
    int         last_srv;
    bit         act;
    int         since, d_at, len, endc;
    bit         ign;
    logic [7:0] h_tx;
    logic [1:0] h_g;
    logic [9:0] h_frame;
    logic       line;
    int         mode;
    bit         rand_req, force_low, idle_low;
    int         stb_cnt;
    int         ack_log[$];
    logic [9:0] exp_bits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Round-robin choice: first requester after the last one served, wrapping.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int j = 1; j <= 4; j++)
            if (r[(last + j) % 4]) return (last + j) % 4;
        return 0;
    endfunction

    task automatic sample();
        s_stb   = bus.stb;
        s_ack   = bus.ack;
        s_grant = bus.grant;
        s_tx    = bus.tx_byte;
        s_busy  = bus.busy;
        s_terr  = bus.timeout_err;
    endtask

    task automatic tick();
        bit          elig;
        logic [3:0]  pr;
        logic [31:0] pd;
        int          e;
        logic        terr_exp;
        elig = (res_n === 1'b1) && !s_busy && bus.rdy && (bus.req != 4'b0000);
        pr   = bus.req;
        pd   = bus.req_data;
        e    = elig ? rr_pick(pr, last_srv) : 0;
        @(negedge clk);
        sample();
        chk("stb", s_stb, elig);
        chk("ack", s_ack, elig ? (4'b0001 << e) : 4'b0000);
        if (elig) begin
            chk("grant", s_grant, e);
            chk("tx_byte", s_tx, pd[8*e +: 8]);
            last_srv = e;
        end
        if (act) since++;
        terr_exp = act && ign && (since == T + 1);
        if (act && since > endc) act = 1'b0;
        if (elig) begin
            act   = 1'b1;
            since = 0;
            h_tx  = pd[8*e +: 8];
            h_g   = 2'(e);
            h_frame = {1'b1, h_tx, 1'b0};
            stb_cnt++;
            ack_log.push_back(e);
            case (mode)
                1:       begin ign = 1'b0; d_at = 3; len = 40; end
                2:       begin ign = 1'b1; d_at = 0; len = 0;  end
                3:       begin ign = 1'b0; d_at = 1; len = 30; end
                default: begin
                    ign  = ($urandom_range(0, 4) == 0);
                    d_at = $urandom_range(1, 5);
                    len  = $urandom_range(1, 6);
                end
            endcase
            endc = ign ? T : d_at + len;
        end
        chk("timeout_err", s_terr, terr_exp);
        chk("busy", s_busy, act);
        if (act && since > 0) begin
            chk("tx_hold", s_tx, h_tx);
            chk("grant_hold", s_grant, h_g);
        end
        // Transmitter: rdy for the coming cycle
        if (act && !ign && since >= d_at && since < d_at + len) bus.rdy = 1'b0;
        else if (!act && force_low)                              bus.rdy = 1'b0;
        else if (!act && idle_low && $urandom_range(0, 3) == 0)  bus.rdy = 1'b0;
        else                                                     bus.rdy = 1'b1;
        line = (act && mode == 3 && since >= 1 && since <= 30) ? h_frame[(since - 1) / 3] : 1'b1;
        // Requesters hold req and byte until acked
        if (rand_req) begin
            for (int i = 0; i < 4; i++) begin
                if (s_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) bus.req[i] = 1'b0;
                    else bus.req_data[8*i +: 8] = 8'($urandom);
                end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
    endtask

    task automatic wait_idle(input int bound);
        int c;
        c = 0;
        while ((act || s_busy) && c < bound) begin
            tick();
            c++;
        end
        chk("drain", (act || s_busy), 1'b0);
    endtask

    task automatic wait_stb(input string tag, input int bound);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (!s_stb && c < bound);
        chk(tag, s_stb, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        res_n = 1'b0;
        bus.req = 4'b0000;
        bus.req_data = 32'h0;
        bus.rdy = 1'b1;
        mode = 0; rand_req = 1'b0; force_low = 1'b0; idle_low = 1'b0;
        act = 1'b0; since = 0; d_at = 0; len = 0; endc = 0; ign = 1'b0;
        last_srv = 3; stb_cnt = 0; line = 1'b1; h_frame = 10'h3FF;
        exp_bits = 10'b1001111000;

        // Reset values
        #1;
        sample();
        chk("rst_stb", s_stb, 1'b0);
        chk("rst_ack", s_ack, 4'b0000);
        chk("rst_terr", s_terr, 1'b0);
        chk("rst_tx", s_tx, 8'h00);
        chk("rst_grant", s_grant, 2'd0);
        chk("rst_busy", s_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;

        // Full contention, transmitter drops rdy 3 after stb for 40 cycles
        mode = 1;
        bus.req = 4'hF;
        bus.req_data = 32'h44332211;
        stb_cnt = 0;
        ack_log.delete();
        for (int c = 0; c < 400 && stb_cnt < 5; c++) tick();
        bus.req = 4'h0;
        chk("contention_count", stb_cnt, 5);
        for (int k = 0; k < 5; k++)
            chk("contention_order", (k < ack_log.size()) ? ack_log[k] : -1, k % 4);
        wait_idle(100);

        // Single request
        mode = 0;
        bus.req = 4'b0001;
        bus.req_data = 32'h000000A5;
        tick();
        chk("single_stb", s_stb, 1'b1);
        chk("single_ack", s_ack, 4'b0001);
        chk("single_tx", s_tx, 8'hA5);
        chk("single_busy", s_busy, 1'b1);
        bus.req = 4'b0000;
        wait_idle(100);

        // Blocked transmitter
        force_low = 1'b1;
        bus.rdy = 1'b0;
        bus.req = 4'b0100;
        bus.req_data = 32'h00C30000;
        repeat (5) begin
            tick();
            chk("blocked_stb", s_stb, 1'b0);
            chk("blocked_busy", s_busy, 1'b0);
        end
        force_low = 1'b0;
        bus.rdy = 1'b1;
        tick();
        chk("unblocked_stb", s_stb, 1'b1);
        chk("unblocked_tx", s_tx, 8'hC3);
        bus.req = 4'b0000;
        wait_idle(100);

        // Timeout: rdy stays high after stb
        mode = 2;
        bus.req = 4'b0110;
        bus.req_data = 32'h0055AA00;
        wait_stb("to_first_stb", 10);
        chk("to_first_grant", s_grant, 2'd1);
        mode = 0;
        n = 0;
        while (!s_terr && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, T + 1);
        chk("timeout_idle", s_busy, 1'b0);
        tick();
        chk("to_next_stb", s_stb, 1'b1);
        chk("to_next_grant", s_grant, 2'd2);
        bus.req = 4'b0000;
        wait_idle(100);

        // Randomized traffic
        mode = 0;
        idle_low = 1'b1;
        rand_req = 1'b1;
        repeat (1500) tick();
        rand_req = 1'b0;
        idle_low = 1'b0;
        bus.req = 4'b0000;
        wait_idle(200);

        // Serial frame of 8'h3C through the UART model
        mode = 3;
        bus.req = 4'b0001;
        bus.req_data = 32'h0000003C;
        wait_stb("uart_stb", 10);
        chk("uart_tx", s_tx, 8'h3C);
        bus.req = 4'b0000;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c % 3 == 2) chk("uart_bit", line, exp_bits[c / 3]);
        end
        wait_idle(100);

        // Reset in WDON with grant 2
        mode = 1;
        bus.req = 4'b0100;
        bus.req_data = 32'h00770000;
        wait_stb("wdon_stb", 10);
        bus.req = 4'b0000;
        repeat (6) tick();
        chk("wdon_grant", s_grant, 2'd2);
        chk("wdon_busy", s_busy, 1'b1);
        #2 res_n = 1'b0;
        #1;
        sample();
        chk("mid_rst_stb", s_stb, 1'b0);
        chk("mid_rst_ack", s_ack, 4'b0000);
        chk("mid_rst_terr", s_terr, 1'b0);
        chk("mid_rst_tx", s_tx, 8'h00);
        chk("mid_rst_grant", s_grant, 2'd0);
        chk("mid_rst_busy", s_busy, 1'b0);
        act = 1'b0;
        last_srv = 3;
        bus.rdy = 1'b1;
        bus.req = 4'b0110;
        bus.req_data = 32'h00BBAA00;
        repeat (3) begin
            @(negedge clk);
            sample();
            chk("in_rst_stb", s_stb, 1'b0);
            chk("in_rst_ack", s_ack, 4'b0000);
        end
        res_n = 1'b1;
        tick();
        chk("post_rst_ack", s_ack, 4'b0010);
        chk("post_rst_tx", s_tx, 8'hAA);
        bus.req = 4'b0000;
        wait_idle(200);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum clk cycles in WBSY waiting for rdy to fall before the transfer is abandoned.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1: sole clock; all registers update on its rising edge.
REQ-004 Port res_n, input, 1: asynchronous active-low reset.
REQ-005 Port req, input, 4: per-requester byte-pending request; bit i belongs to requester i.
REQ-006 Port req_data, input, 32: packed request bytes; requester i drives bits [8i+7:8i].
REQ-007 Port ack, output, 4: one-hot, one-cycle pulse; byte of requester i handed to transmitter.
REQ-008 Port grant, output, 2: index of the requester currently or last served.
REQ-009 Port tx_byte, output, 8: byte presented to the UART transmitter.
REQ-010 Port stb, output, 1: one-cycle strobe to the UART transmitter.
REQ-011 Port rdy, input, 1: transmitter idle indication (high = transmitter in WAIT).
REQ-012 Port busy, output, 1: high whenever state is not IDLE.
REQ-013 Port timeout_err, output, 1: one-cycle pulse on abandoned transfer.

Function
REQ-014 The block SHALL implement states IDLE, STRB, WBSY and WDON.
REQ-015 In IDLE with rdy=1 and req nonzero, the block SHALL select the first set req bit searching from (last_grant+1) mod 4 upward with wrap, latch its index into grant and its req_data byte into tx_byte, and enter STRB next cycle.
REQ-016 In IDLE with rdy=0 or req=0, the block SHALL remain in IDLE and leave grant/tx_byte unchanged.
REQ-017 In STRB, stb SHALL be 1 and ack[grant] SHALL be 1 for exactly that one cycle; next state WBSY.
REQ-018 stb and ack SHALL be 0 in every state except STRB.
REQ-019 tx_byte SHALL remain constant from STRB until return to IDLE.
REQ-020 In WBSY, rdy=0 SHALL move to WDON; otherwise a cycle counter increments.
REQ-021 If the WBSY counter reaches TIMEOUT with rdy still 1, timeout_err SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-022 The WBSY counter SHALL clear on entry to WBSY and be ceil(log2(TIMEOUT+1)) bits wide, never wrapping.
REQ-023 In WDON, rdy=1 SHALL return to IDLE; there is no timeout in WDON.
REQ-024 last_grant SHALL update to grant on every exit from WBSY or WDON to IDLE, including timeout.
REQ-025 Request-to-stb latency SHALL be exactly 1 cycle (req sampled in IDLE, stb on the following cycle).
REQ-026 Requesters SHALL hold req and their byte until ack; deasserting req after grant latch SHALL NOT cancel the transfer.
REQ-027 A requester with continuous req and no competitors SHALL be served on every IDLE visit.
REQ-028 With all four requesting continuously, the grant order SHALL be 0,1,2,3,0,...
REQ-029 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-030 On res_n=0, the block SHALL immediately set state IDLE, stb 0, ack 0, timeout_err 0, tx_byte 8'h00, grant 0, last_grant 3, counter 0.
REQ-031 Reset asserted mid-transfer SHALL abort with no ack or stb emitted afterward; the first grant after release SHALL go to the lowest-indexed active requester.

Verification
REQ-032 Single request: req=4'b0001, req_data[7:0]=8'hA5, rdy=1 -> next cycle stb=1, ack=4'b0001, tx_byte=8'hA5, busy=1.
REQ-033 Full contention: req=4'hF held, transmitter model drops rdy 3 cycles after stb and raises it 40 cycles later -> acks in order 0,1,2,3,0, with exactly one stb per byte.
REQ-034 Timeout: rdy held 1 after stb -> timeout_err pulses exactly TIMEOUT+1 cycles after stb, then IDLE; the next grant moves to the following requester.
REQ-035 Blocked transmitter: rdy=0 in IDLE with req=4'b0100 -> no stb and busy=0 until rdy=1, then stb on the next cycle.
REQ-036 Reset mid-transfer: res_n pulsed low in WDON with grant=2 -> outputs at reset values immediately; after release with req=4'b0110, the first ack is 4'b0010.
REQ-037 End-to-end: connect to the UART transmitter, send 8'h3C -> serial line shows start bit 0, data LSB first 0,0,1,1,1,1,0,0, then stop bit 1.
